qam_demod_packer: RTL
=====================

Name: qam_demod_packer

Overview:
- Receive-side counterpart of the QAM modulator top.
- Accepts equalised I/Q symbol samples and hard-slices each one to 1, 2 or 4 bits according to the qam mode (BPSK / QPSK / 16-QAM).
- Packs the sliced bits LSB-first into 32-bit words, the inverse of the modulator's right-shift serialisation.
- Presents the words on a valid/ready output with backpressure to the symbol source.

Parameters:
- SAMPLE_W, 16, signed width of i_in/q_in.
- THRESH, 8192, 16-QAM inner/outer decision magnitude on each axis; positive, < 2^(SAMPLE_W-1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- qam  input  3  mode: 0=BPSK, 1=QPSK, 2=16-QAM, 3..7 invalid.
- i_in  input  SAMPLE_W  signed in-phase sample.
- q_in  input  SAMPLE_W  signed quadrature sample.
- sym_valid  input  1  i_in/q_in hold a symbol.
- sym_ready  output  1  block can accept a symbol.
- word_out  output  32  packed data word.
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  downstream accepts word_out.
- error  output  1  sticky invalid-mode flag.

Behaviour:
- Reset (async assert, sync release): sym_ready=0 while rst is high, 1 on the first clock after release. word_out=0, word_valid=0, error=0, accumulator=0, bit count=0, latched mode=BPSK, state=ACCUM.
- Reset mid-word discards the partial accumulator and any held word.
- A symbol is accepted when sym_valid and sym_ready are both high at a clock edge. A word is consumed when word_valid and word_ready are both high.
- Mode latch: the effective mode is decode(qam) when bit count = 0, otherwise the latched mode. It is latched on acceptance of the first symbol of each word. qam changes mid-word are ignored until the next word boundary.
- Invalid qam (3..7) at a word boundary: slice and pack as BPSK, and set error=1. error stays high until rst.
- Slicer, per axis value v:
  - s = (v < 0); zero counts as positive.
  - m = (v >= THRESH) or (v <= -THRESH).
  - Use compares only, no abs(), so the most negative value is safe.
- Bits per symbol (bps):
  - BPSK: bps=1, bits = {I_s}.
  - QPSK: bps=2, bits = {Q_s, I_s}.
  - 16-QAM: bps=4, bits = {Q_s, Q_m, I_s, I_m}.
- Packing:
  - Per accepted symbol: acc <= {bits, acc[31:bps]}; count += bps. The first symbol ends in the LSBs.
  - A word is complete when count reaches 32, i.e. after 32, 16 or 8 symbols.
- State ACCUM, sym_ready=1:
  - When the completing symbol is accepted and the output register is empty, or is being consumed in the same cycle: word_out <= completed word, word_valid=1 next cycle, count <= 0, acc <= 0.
  - Latency: 1 cycle from the final symbol edge to word_valid.
  - If the output register is held (word_valid=1, word_ready=0): keep the completed word in acc and go to FULL.
- State FULL, sym_ready=0:
  - On consumption of word_out: word_out <= acc, word_valid stays 1, count <= 0, return to ACCUM.
  - sym_ready returns to 1 the cycle after consumption.
- word_valid, once high, holds word_out stable until consumed.
- word_valid deasserts the cycle after consumption unless a new word is loaded in the same edge.
- Simultaneous consume and completion in ACCUM: the new word is loaded and word_valid stays 1 with no bubble.
- No data is dropped under any backpressure pattern; throughput is 1 symbol/cycle while word_ready=1.

Test Plan:
- Reset, then BPSK (qam=0), word_ready=1, 32 symbols with I alternating -100,+100 starting negative, Q=0 -> one word 0x55555555; word_valid high one cycle; error=0.
- QPSK (qam=1), 16 symbols with I=+5000, Q=-5000 -> word 0xAAAAAAAA. Then qam switched to 0 after symbol 5 of the next QPSK word -> that word still packs 16 QPSK symbols.
- 16-QAM (qam=2), 8 symbols with I=+12000, Q=-3000 -> word 0x99999999. Repeat with I=-32768, Q=0 -> nibble 0x3, word 0x33333333.
- Backpressure: BPSK, word_ready=0, 64 symbols with I=-1 -> sym_ready drops after the 64th acceptance. Raise word_ready -> two words 0xFFFFFFFF in order, sym_ready back to 1; no symbol lost.
- qam=5 at a word boundary, 32 symbols with I=+1 -> error=1 from the first acceptance, word 0x00000000 packed as BPSK. error remains 1 after qam returns to 0, until rst.
- rst asserted asynchronously after 10 of 16 QPSK symbols -> outputs clear immediately without a clock edge. A fresh 16 symbols then yield a clean word with no residue from before reset.

Source files
------------

// File: rtl/qam_demod_packer.sv
// QAM receive slicer and word packer.
// Hard-slices I/Q symbols and packs the bits LSB-first into 32-bit words.
module qam_demod_packer #(
  parameter int SAMPLE_W = 16,
  parameter int THRESH   = 8192
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 qam,
  input  logic signed [SAMPLE_W-1:0] i_in,
  input  logic signed [SAMPLE_W-1:0] q_in,
  input  logic                       sym_valid,
  output logic                       sym_ready,
  output logic [31:0]                word_out,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic                       error
);

  typedef enum logic {ACCUM, FULL} state_t;
  typedef enum logic [1:0] {
    M_BPSK,
    M_QPSK,
    M_QAM16
  } mode_t;

  localparam logic signed [SAMPLE_W-1:0] POS_TH =
    SAMPLE_W'(THRESH);
  localparam logic signed [SAMPLE_W-1:0] NEG_TH =
    SAMPLE_W'(-THRESH);

  state_t      state_q, state_d;
  mode_t       mode_q, mode_d;
  mode_t       dec_mode, eff_mode;
  logic        dec_bad;
  logic [31:0] acc_q, acc_d;
  logic [31:0] word_q, word_d;
  logic [31:0] shifted;
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  bps, cnt_sum;
  logic        wv_q, wv_d;
  logic        err_q, err_d;
  logic        rdy_q;
  logic        i_s, i_m, q_s, q_m;
  logic        accept, consume;

  assign sym_ready  = rdy_q && (state_q == ACCUM);
  assign word_out   = word_q;
  assign word_valid = wv_q;
  assign error      = err_q;

  assign accept  = sym_valid && sym_ready;
  assign consume = wv_q && word_ready;

  // Compare-only slicing keeps the most negative sample safe.
  assign i_s = i_in < 0;
  assign q_s = q_in < 0;
  assign i_m = (i_in >= POS_TH) || (i_in <= NEG_TH);
  assign q_m = (q_in >= POS_TH) || (q_in <= NEG_TH);

  always_comb begin
    dec_mode = M_BPSK;
    dec_bad  = 1'b0;
    case (qam)
      3'd0:    dec_mode = M_BPSK;
      3'd1:    dec_mode = M_QPSK;
      3'd2:    dec_mode = M_QAM16;
      default: dec_bad  = 1'b1;
    endcase
  end

  // Mode only changes at a word boundary.
  assign eff_mode = (cnt_q == 6'd0) ? dec_mode : mode_q;

  always_comb begin
    bps     = 6'd1;
    shifted = {i_s, acc_q[31:1]};
    unique case (eff_mode)
      M_QPSK: begin
        bps     = 6'd2;
        shifted = {q_s, i_s, acc_q[31:2]};
      end
      M_QAM16: begin
        bps     = 6'd4;
        shifted = {q_s, q_m, i_s, i_m, acc_q[31:4]};
      end
      default: begin
        bps     = 6'd1;
        shifted = {i_s, acc_q[31:1]};
      end
    endcase
  end

  assign cnt_sum = cnt_q + bps;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    wv_d    = wv_q && !word_ready;
    mode_d  = mode_q;
    err_d   = err_q;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          if (cnt_q == 6'd0) begin
            mode_d = dec_mode;
            err_d  = err_q || dec_bad;
          end
          if (cnt_sum == 6'd32) begin
            if (!wv_q || word_ready) begin
              word_d = shifted;
              wv_d   = 1'b1;
              acc_d  = '0;
              cnt_d  = '0;
            end else begin
              acc_d   = shifted;
              cnt_d   = cnt_sum;
              state_d = FULL;
            end
          end else begin
            acc_d = shifted;
            cnt_d = cnt_sum;
          end
        end
      end
      FULL: begin
        if (consume) begin
          word_d  = acc_q;
          wv_d    = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      wv_q    <= 1'b0;
      mode_q  <= M_BPSK;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wv_q    <= wv_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      rdy_q   <= 1'b1;
    end
  end

endmodule
